// File: rtl/intr_ctrl.sv
// Interrupt request controller: edge-latched requests, mask, fixed priority (bit 0 highest),
// request/ack/reti handshake with the CPU. Define INTR_NESTING_EN to allow preemption in SERVICE.
module intr_ctrl #(
    parameter int N_INTR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_INTR-1:0] intr_req,
    input  logic              mask_we,
    input  logic [N_INTR-1:0] mask_in,
    input  logic              intr_ack,
    input  logic              intr_reti,
    output logic              intr,
    output logic [N_INTR-1:0] intr_selec,
    output logic [N_INTR-1:0] intr_pend,
    output logic [N_INTR-1:0] intr_insrv,
    output logic [N_INTR-1:0] intr_mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state;
    logic [N_INTR-1:0] req_prev;
    logic [N_INTR-1:0] pend;
    logic [N_INTR-1:0] insrv;
    logic [N_INTR-1:0] mask;
    logic [N_INTR-1:0] selec;
    logic              intr_r;
    logic [N_INTR-1:0] rise;
    logic [N_INTR-1:0] cand;
    logic [N_INTR-1:0] win;
`ifdef INTR_NESTING_EN
    logic [N_INTR-1:0] insrv_top;
    logic [N_INTR-1:0] insrv_rem;
`endif

    // One-hot of the lowest set bit, i.e. the highest-priority line.
    function automatic logic [N_INTR-1:0] lowest(input logic [N_INTR-1:0] v);
        logic [N_INTR-1:0] r;
        r = '0;
        for (int i = N_INTR - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        rise = intr_req & ~req_prev;
        cand = pend & mask;
        win  = lowest(cand);
`ifdef INTR_NESTING_EN
        insrv_top = lowest(insrv);
        insrv_rem = insrv & ~insrv_top;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_prev <= '1;
            pend     <= '0;
            insrv    <= '0;
            mask     <= '0;
            selec    <= '0;
            intr_r   <= 1'b0;
        end else begin
            req_prev <= intr_req;
            pend     <= pend | rise;
            if (mask_we)
                mask <= mask_in;

            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        selec  <= win;
                        intr_r <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // selec stays frozen here; a fresh edge on the acked line re-pends it.
                    if (intr_ack) begin
                        pend   <= (pend & ~selec) | rise;
                        insrv  <= insrv | selec;
                        intr_r <= 1'b0;
                        state  <= SERVICE;
                    end
                end
                SERVICE: begin
`ifdef INTR_NESTING_EN
                    if (intr_reti) begin
                        insrv <= insrv_rem;
                        selec <= lowest(insrv_rem);
                        state <= (insrv_rem != '0) ? SERVICE : IDLE;
                    end else if ((win != '0) && (win < insrv_top)) begin
                        selec  <= win;
                        intr_r <= 1'b1;
                        state  <= REQ;
                    end
`else
                    if (intr_reti) begin
                        insrv <= insrv & ~selec;
                        selec <= '0;
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign intr       = intr_r;
    assign intr_selec = selec;
    assign intr_pend  = pend;
    assign intr_insrv = insrv;
    assign intr_mask  = mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: expected grants are queued when requests are driven
// and popped when the controller raises intr.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] intr_req;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       intr_ack;
    logic       intr_reti;
    logic       intr;
    logic [7:0] intr_selec;
    logic [7:0] intr_pend;
    logic [7:0] intr_insrv;
    logic [7:0] intr_mask;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    intr_ctrl #(.N_INTR(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .intr_req  (intr_req),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .intr_ack  (intr_ack),
        .intr_reti (intr_reti),
        .intr      (intr),
        .intr_selec(intr_selec),
        .intr_pend (intr_pend),
        .intr_insrv(intr_insrv),
        .intr_mask (intr_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    // Wait (bounded) for intr, then compare the granted line against the scoreboard head.
    task automatic wait_grant(input string tag, input int max_cycles);
        logic [7:0] exp;
        for (int i = 0; i < max_cycles && intr !== 1'b1; i++)
            tick();
        chk({tag, "_intr"}, {7'd0, intr}, 8'h01);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, intr_selec, 8'h00);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_selec"}, intr_selec, exp);
        end
    endtask

    // Full ack/reti cycle for the granted line; both=1 asserts ack and reti together each time.
    task automatic serve(input string tag, input logic [7:0] sel, input bit both);
        intr_ack  = 1'b1;
        intr_reti = both;
        tick();
        intr_ack  = 1'b0;
        intr_reti = 1'b0;
        chk({tag, "_ack_insrv"}, intr_insrv, sel);
        chk({tag, "_ack_intr"}, {7'd0, intr}, 8'h00);
        chk({tag, "_ack_selec"}, intr_selec, sel);
        intr_reti = 1'b1;
        intr_ack  = both;
        tick();
        intr_reti = 1'b0;
        intr_ack  = 1'b0;
        chk({tag, "_reti_insrv"}, intr_insrv, 8'h00);
        chk({tag, "_reti_selec"}, intr_selec, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; intr_req = 8'h00; mask_we = 1'b0; mask_in = 8'h00;
        intr_ack = 1'b0; intr_reti = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_selec", intr_selec, 8'h00);
        chk("rst_pend", intr_pend, 8'h00);
        chk("rst_insrv", intr_insrv, 8'h00);
        chk("rst_mask", intr_mask, 8'h00);

        // Idle ack/reti with nothing pending must be ignored
        intr_ack = 1'b1; intr_reti = 1'b1;
        tick();
        intr_ack = 1'b0; intr_reti = 1'b0;
        chk("idle_ack_insrv", intr_insrv, 8'h00);
        chk("idle_ack_intr", {7'd0, intr}, 8'h00);

        // Single line 3, two-cycle latency
        set_mask(8'hFF);
        chk("mask_ff", intr_mask, 8'hFF);
        sb.push_back(8'h08);
        intr_req = 8'h08;
        tick();
        chk("l3_pend", intr_pend, 8'h08);
        chk("l3_intr_early", {7'd0, intr}, 8'h00);
        wait_grant("l3", 1);
        intr_req = 8'h00;
        serve("l3", 8'h08, 1'b0);

        // Lines 0 and 7 together: 0 first, then 7; ack+reti asserted together
        sb.push_back(8'h01);
        sb.push_back(8'h80);
        intr_req = 8'h81;
        tick();
        intr_req = 8'h00;
        wait_grant("l07a", 4);
        serve("l07a", 8'h01, 1'b1);
        wait_grant("l07b", 4);
        serve("l07b", 8'h80, 1'b0);

        // Masked line stays pending, unmasking releases it
        set_mask(8'hFE);
        intr_req = 8'h01;
        tick(); tick(); tick();
        chk("mask_intr", {7'd0, intr}, 8'h00);
        chk("mask_pend", intr_pend, 8'h01);
        sb.push_back(8'h01);
        set_mask(8'hFF);
        wait_grant("unmask", 2);
        intr_req = 8'h00;
        serve("unmask", 8'h01, 1'b0);

        // Line 5 in REQ; line 1 arrives later; new edge on 5 with ack
        sb.push_back(8'h20);
        intr_req = 8'h20;
        tick();
        wait_grant("l5", 2);
        intr_req = 8'h22;
        tick();
        chk("l5_frozen", intr_selec, 8'h20);
        intr_req = 8'h02;
        tick();
        chk("l5_frozen2", intr_selec, 8'h20);
        intr_req = 8'h22;
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        chk("l5_ack_pend", intr_pend, 8'h22);
        chk("l5_ack_insrv", intr_insrv, 8'h20);
        sb.push_back(8'h02);
        sb.push_back(8'h20);
        intr_reti = 1'b1;
        tick();
        intr_reti = 1'b0;
        chk("l5_reti_insrv", intr_insrv, 8'h00);
        wait_grant("l1", 4);
        serve("l1", 8'h02, 1'b0);
        wait_grant("l5b", 4);
        serve("l5b", 8'h20, 1'b0);
        intr_req = 8'h00;
        tick();

        // Lines high through reset release are not edges
        intr_req = 8'hFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_mask(8'hFF);
        tick(); tick();
        chk("hold_pend", intr_pend, 8'h00);
        chk("hold_intr", {7'd0, intr}, 8'h00);

        // Reset while in SERVICE with another line pending
        intr_req = 8'h00;
        tick();
        sb.push_back(8'h10);
        intr_req = 8'h10;
        tick();
        wait_grant("l4", 2);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        chk("svc_insrv", intr_insrv, 8'h10);
`ifdef INTR_NESTING_EN
        // Line 2 preempts line 4
        sb.push_back(8'h04);
        intr_req = 8'h14;
        tick();
        wait_grant("nest", 2);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        chk("nest_ack_insrv", intr_insrv, 8'h14);
        intr_reti = 1'b1;
        tick();
        intr_reti = 1'b0;
        chk("nest_reti_insrv", intr_insrv, 8'h10);
        chk("nest_reti_selec", intr_selec, 8'h10);
        intr_req = 8'h50;
`else
        intr_req = 8'h50;
`endif
        tick();
        chk("svc_pend", intr_pend & 8'h40, 8'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("svcrst_intr", {7'd0, intr}, 8'h00);
        chk("svcrst_selec", intr_selec, 8'h00);
        chk("svcrst_pend", intr_pend, 8'h00);
        chk("svcrst_insrv", intr_insrv, 8'h00);
        chk("svcrst_mask", intr_mask, 8'h00);
        set_mask(8'hFF);
        tick(); tick();
        chk("svcrst_idle", {7'd0, intr}, 8'h00);

        chk("sb_left", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt request controller for the basic CPU. It is the requesting end of the interrupt vector path.
- Latches edge-triggered requests on 8 lines, applies a mask, and picks the highest-priority line. It drives a one-hot select to the vector lookup block, which turns it into a 10-bit ISR address.
- Handshakes with the CPU control unit: request, then acknowledge, then return from interrupt. Tracks which lines are in service.

Parameters:
- N_INTR, 8, number of interrupt lines. Fixed at 8 to match the vector lookup width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- intr_req  in  8  external request lines, synchronous to clk; rising edge = request
- mask_we  in  1  write enable for the mask register
- mask_in  in  8  new mask value; 1 = line enabled
- intr_ack  in  1  CPU has saved PC and jumped to the vector (1-cycle pulse)
- intr_reti  in  1  CPU executed return-from-interrupt (1-cycle pulse)
- intr  out  1  interrupt request to the CPU
- intr_selec  out  8  one-hot winner, goes to the vector lookup block; 0 when there is no winner
- intr_pend  out  8  latched pending requests (status)
- intr_insrv  out  8  in-service bits (status)
- intr_mask  out  8  current mask

Behaviour:
- Reset values:
  - intr=0, intr_selec=0, intr_pend=0, intr_insrv=0, intr_mask=8'h00 (all lines disabled).
  - State=IDLE.
  - Previous-sample register for edge detection = 8'hFF, so lines already high at reset release are not treated as edges.
- Edge detect: on a clk edge where req_prev[i]=0 and intr_req[i]=1, pend[i] is set. req_prev is updated every cycle.
- Priority: bit 0 is highest, bit 7 is lowest.
- Candidate set: cand = pend & mask. The winner is the lowest set bit of cand, as a one-hot value.
- Mask write: intr_mask updates on the edge where mask_we=1.
  - Masking a line does not clear its pending bit.
  - Masking does not withdraw a request already in REQ.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if cand≠0, go to REQ next edge. Register the winner into intr_selec and set intr=1.
  - REQ: intr_selec is frozen; a higher-priority line arriving later does not replace it. On intr_ack, on that edge:
    - clear pend[sel]
    - set insrv[sel]
    - intr=0
    - go to SERVICE
    - intr_selec stays held.
  - SERVICE: on intr_reti, clear insrv[sel], set intr_selec=0, go to IDLE.
  - New edges keep latching into pend while in any state.
- Latency: an edge sampled at clk edge k sets pend after edge k. intr=1 and intr_selec are valid after edge k+1 (2 cycles total).
- Boundary conditions:
  - New rising edge on the same line as a clear by intr_ack in the same cycle: the new edge wins, and pend stays 1.
  - intr_ack outside REQ is ignored.
  - intr_reti outside SERVICE is ignored.
  - intr_ack and intr_reti asserted together: only the one valid for the current state is acted on.
  - reset in any state returns everything to reset values on that edge. Pending requests are discarded.
  - All 8 lines rising at once: they are serviced in order 0..7, one full ack/reti cycle each.

Optional Feature:
- Macro: INTR_NESTING_EN
- Defined:
  - In SERVICE, if the winner of cand has higher priority than the highest-priority set bit of insrv, go to REQ with that winner and set intr=1.
  - On intr_ack, set its insrv bit (nested).
  - On intr_reti, clear the highest-priority insrv bit. intr_selec becomes the one-hot of the next remaining insrv bit and the FSM stays in SERVICE, or goes to IDLE with intr_selec=0 if insrv is then empty.
  - Maximum nesting depth is 8.
- Not defined:
  - No preemption in SERVICE. insrv has at most one bit set.

Test Plan:
- Reset, then write mask 8'hFF, then pulse intr_req[3] high. Required: intr=1 and intr_selec=8'h08 two cycles after the sampled edge; intr_pend=8'h08.
- Raise intr_req 8'h81 in one cycle. Required: intr_selec=8'h01 first. After ack and reti, intr_selec=8'h80 follows. intr_insrv shows 8'h01, then 8'h80.
- Mask 8'hFE, then raise intr_req[0]. Required: intr stays 0 and intr_pend=8'h01. Writing mask 8'hFF then gives intr=1 and intr_selec=8'h01.
- While in REQ for line 5, raise line 1. Required: intr_selec stays 8'h20 until ack. Line 1 is requested after reti. The same-cycle ack plus new edge on line 5 leaves pend[5]=1.
- Hold intr_req=8'hFF through reset release. Required: no pending bits set. Assert reset while in SERVICE: all outputs return to 0 and the FSM is IDLE.
- With INTR_NESTING_EN, in SERVICE for line 4, raise line 2. Required: intr=1, selec=8'h04. After ack, insrv=8'h14. After reti, insrv=8'h10 and selec=8'h10.
